// File: rtl/cache_cfg_pkg.sv
// rtl/cache_cfg_pkg.sv - shared cache geometry types, defaults and helpers
//
// Contents:
//   cfg_t              build-time cache configuration (set associativity per cache)
//   NPC_CFG            the configuration this core is built with
//   DEFAULT_NUM_CACHES number of reconfigurable caches (0 = ICache, 1 = DCache)
//   DEFAULT_MAX_WAYS   largest associativity among the caches
//   resp_err_e         reconfiguration result codes
//   popcount()         number of set bits in a mask of up to 32 ways
package cache_cfg_pkg;

    typedef struct packed {
        int unsigned icache_set_assoc;
        int unsigned dcache_set_assoc;
    } cfg_t;

    localparam cfg_t NPC_CFG = '{icache_set_assoc: 32'd4, dcache_set_assoc: 32'd4};

    localparam int unsigned DEFAULT_NUM_CACHES = 2;
    localparam int unsigned DEFAULT_MAX_WAYS =
        (NPC_CFG.icache_set_assoc > NPC_CFG.dcache_set_assoc) ?
        NPC_CFG.icache_set_assoc : NPC_CFG.dcache_set_assoc;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_BAD_MASK  = 2'b01,
        ERR_TIMEOUT   = 2'b10,
        ERR_BAD_CACHE = 2'b11
    } resp_err_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_way_cfg_ctrl_check.sv
// rtl/cache_way_cfg_ctrl_check.sv - combinational way-mask validation
//
// Ports:
//   mask       requested enabled-way mask
//   cur_mask   mask currently applied to the target cache
//   valid      mask is nonzero and contiguous from way 0
//   equal      mask matches cur_mask (reconfiguration is a no-op)
//   pop_count  number of ways enabled by mask
module way_mask_check
    import cache_cfg_pkg::*;
#(
    parameter int unsigned MAX_WAYS = DEFAULT_MAX_WAYS,
    parameter int unsigned AW       = $clog2(MAX_WAYS + 1)
) (
    input  logic [MAX_WAYS-1:0] mask,
    input  logic [MAX_WAYS-1:0] cur_mask,
    output logic                valid,
    output logic                equal,
    output logic [AW-1:0]       pop_count
);

    logic [MAX_WAYS-1:0] mask_inc;

    // A contiguous low-order run of ones carries all the way out when
    // incremented, so it shares no bit with its successor. The all-ones mask
    // wraps to zero here, which is exactly the behaviour wanted.
    assign mask_inc  = mask + MAX_WAYS'(1);
    assign valid     = (mask != '0) && ((mask_inc & mask) == '0);
    assign equal     = (mask == cur_mask);
    assign pop_count = AW'(popcount(32'(mask)));

endmodule

// File: rtl/cache_way_cfg_ctrl.sv
// rtl/cache_way_cfg_ctrl.sv - runtime per-cache way-mask reconfiguration controller
//
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   req_valid_i      reconfiguration request valid
//   req_ready_o      request accepted when high (only in IDLE)
//   req_cache_i      target cache index (0 = ICache, 1 = DCache)
//   req_way_mask_i   requested enabled-way mask
//   resp_valid_o     one-cycle completion pulse
//   resp_err_o       result code (resp_err_e), valid with resp_valid_o
//   flush_req_o      per-cache flush request, held while waiting for ack
//   flush_ack_i      per-cache flush done pulse
//   way_mask_o       enabled ways, cache c at [c*MAX_WAYS +: MAX_WAYS]
//   active_ways_o    popcount of each cache's mask, cache c at [c*AW +: AW]
//   busy_o           high whenever a request is in progress
module cache_way_cfg_ctrl
    import cache_cfg_pkg::*;
#(
    parameter int unsigned NUM_CACHES    = DEFAULT_NUM_CACHES,
    parameter int unsigned MAX_WAYS      = DEFAULT_MAX_WAYS,
    parameter int unsigned FLUSH_TIMEOUT = 1024,
    localparam int unsigned CW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1,
    localparam int unsigned AW = $clog2(MAX_WAYS + 1),
    localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [CW-1:0]                req_cache_i,
    input  logic [MAX_WAYS-1:0]          req_way_mask_i,
    output logic                         resp_valid_o,
    output logic [1:0]                   resp_err_o,
    output logic [NUM_CACHES-1:0]        flush_req_o,
    input  logic [NUM_CACHES-1:0]        flush_ack_i,
    output logic [NUM_CACHES*MAX_WAYS-1:0] way_mask_o,
    output logic [NUM_CACHES*AW-1:0]     active_ways_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FLUSH = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                               state_q, state_d;
    logic [CW-1:0]                        cache_q, cache_d;
    logic [MAX_WAYS-1:0]                  mask_q, mask_d;
    resp_err_e                            err_q, err_d;
    logic [TW-1:0]                        cnt_q, cnt_d;
    logic [NUM_CACHES-1:0][MAX_WAYS-1:0]  ways_q, ways_d;

    logic                  cache_ok;
    logic [MAX_WAYS-1:0]   cur_mask;
    logic                  chk_valid;
    logic                  chk_equal;
    logic [AW-1:0]         req_pop;
    logic [NUM_CACHES-1:0] target_oh;
    logic                  ack_hit;

    // Index widths round up to a power of two, so an index can name a cache
    // that does not exist; such requests never touch the mask array.
    assign cache_ok = (32'(cache_q) < NUM_CACHES);
    assign cur_mask = cache_ok ? ways_q[cache_q] : '1;

    way_mask_check #(
        .MAX_WAYS (MAX_WAYS),
        .AW       (AW)
    ) u_check (
        .mask      (mask_q),
        .cur_mask  (cur_mask),
        .valid     (chk_valid),
        .equal     (chk_equal),
        .pop_count (req_pop)
    );

    always_comb begin
        target_oh = '0;
        for (int c = 0; c < NUM_CACHES; c++) begin
            target_oh[c] = (32'(cache_q) == c);
        end
    end

    // Acks on caches other than the target are deliberately masked off.
    assign ack_hit = |(flush_ack_i & target_oh);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cache_q <= '0;
            mask_q  <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            ways_q  <= '1;
        end else begin
            state_q <= state_d;
            cache_q <= cache_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ways_q  <= ways_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cache_d = cache_q;
        mask_d  = mask_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ways_d  = ways_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    cache_d = req_cache_i;
                    mask_d  = req_way_mask_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!cache_ok) begin
                    err_d   = ERR_BAD_CACHE;
                    state_d = S_RESP;
                end else if (!chk_valid || (req_pop == '0)) begin
                    // An empty mask would disable the cache outright.
                    err_d   = ERR_BAD_MASK;
                    state_d = S_RESP;
                end else if (chk_equal) begin
                    err_d   = ERR_OK;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + TW'(1);
                // Ack is checked first so a last-cycle ack still commits.
                if (ack_hit) begin
                    ways_d[cache_q] = mask_q;
                    err_d           = ERR_OK;
                    state_d         = S_RESP;
                end else if (cnt_q == TW'(FLUSH_TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_err_o   = (state_q == S_RESP) ? err_q : ERR_OK;
    assign flush_req_o  = (state_q == S_FLUSH) ? target_oh : '0;
    assign way_mask_o   = ways_q;

    for (genvar c = 0; c < NUM_CACHES; c++) begin : g_active
        assign active_ways_o[c*AW +: AW] = AW'(popcount(32'(ways_q[c])));
    end

endmodule

// File: tb/tb_cache_way_cfg_ctrl.sv
// tb/tb_cache_way_cfg_ctrl.sv - scoreboard testbench for cache_way_cfg_ctrl
module tb_cache_way_cfg_ctrl;
    import cache_cfg_pkg::*;

    localparam int NC = 2;
    localparam int MW = 4;
    localparam int FT = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [0:0]    req_cache_i = '0;
    logic [MW-1:0] req_way_mask_i = '0;
    logic          resp_valid_o;
    logic [1:0]    resp_err_o;
    logic [NC-1:0] flush_req_o;
    logic [NC-1:0] flush_ack_i = '0;
    logic [NC*MW-1:0] way_mask_o;
    logic [NC*AW-1:0] active_ways_o;
    logic          busy_o;

    cache_way_cfg_ctrl #(
        .NUM_CACHES    (NC),
        .MAX_WAYS      (MW),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_cache_i    (req_cache_i),
        .req_way_mask_i (req_way_mask_i),
        .resp_valid_o   (resp_valid_o),
        .resp_err_o     (resp_err_o),
        .flush_req_o    (flush_req_o),
        .flush_ack_i    (flush_ack_i),
        .way_mask_o     (way_mask_o),
        .active_ways_o  (active_ways_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]       err;
        int               cyc;
        logic [NC*MW-1:0] mask;
        int               flush_n;
        logic [NC-1:0]    flush_vec;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts flush-request cycles and checks every response.
    int            fl_n = 0;
    logic [NC-1:0] fl_vec = '0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            fl_n   = 0;
            fl_vec = '0;
        end else begin
            if (flush_req_o != '0) begin
                fl_n++;
                fl_vec = flush_req_o;
            end
            if (resp_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_err", 32'(resp_err_o), 32'(e.err));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("way_mask_at_resp", 32'(way_mask_o), 32'(e.mask));
                    check("flush_cycles", 32'(fl_n), 32'(e.flush_n));
                    check("flush_vec", 32'(fl_vec), 32'(e.flush_vec));
                end
                fl_n   = 0;
                fl_vec = '0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    // Issue one request. ack_at / stray_at count FLUSH cycles from 1 (0 = none).
    task automatic run_req(input logic cache, input logic [MW-1:0] mask,
                           input int ack_at, input logic [NC-1:0] ack_vec,
                           input int stray_at, input logic [NC-1:0] stray_vec,
                           input logic [1:0] exp_err, input int exp_lat,
                           input logic [NC*MW-1:0] exp_mask, input int exp_fl,
                           input logic [NC-1:0] exp_vec);
        exp_t e;
        int last;
        @(negedge clk);
        check("req_ready", 32'(req_ready_o), 32'd1);
        e.err = exp_err; e.cyc = cyc + exp_lat; e.mask = exp_mask;
        e.flush_n = exp_fl; e.flush_vec = exp_vec;
        sb.push_back(e);
        req_cache_i    = cache;
        req_way_mask_i = mask;
        req_valid_i    = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        last = (ack_at > stray_at) ? ack_at : stray_at;
        for (int f = 1; f <= last; f++) begin
            @(negedge clk);
            if (f == ack_at)        flush_ack_i = ack_vec;
            else if (f == stray_at) flush_ack_i = stray_vec;
            else                    flush_ack_i = '0;
        end
        if (last > 0) begin
            @(negedge clk);
            flush_ack_i = '0;
        end
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_way_mask", 32'(way_mask_o), 32'hFF);
        check("rst_active_ways", 32'(active_ways_o), 32'o44);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_flush_req", 32'(flush_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);

        // DCache -> 2 ways, ack in third FLUSH cycle.
        run_req(1'b1, 4'b0011, 3, 2'b10, 0, 2'b00, ERR_OK, 5, 8'h3F, 3, 2'b10);
        check("active_after_dcache", 32'(active_ways_o), 32'o24);

        // Invalid masks on ICache.
        run_req(1'b0, 4'b0000, 0, 2'b00, 0, 2'b00, ERR_BAD_MASK, 2, 8'h3F, 0, 2'b00);
        run_req(1'b0, 4'b0101, 0, 2'b00, 0, 2'b00, ERR_BAD_MASK, 2, 8'h3F, 0, 2'b00);
        run_req(1'b0, 4'b0110, 0, 2'b00, 0, 2'b00, ERR_BAD_MASK, 2, 8'h3F, 0, 2'b00);

        // Unchanged masks complete without flushing.
        run_req(1'b0, 4'b1111, 0, 2'b00, 0, 2'b00, ERR_OK, 2, 8'h3F, 0, 2'b00);
        run_req(1'b1, 4'b0011, 0, 2'b00, 0, 2'b00, ERR_OK, 2, 8'h3F, 0, 2'b00);

        // No ack: flush held exactly FT cycles then TIMEOUT.
        run_req(1'b0, 4'b0111, 0, 2'b00, 0, 2'b00, ERR_TIMEOUT, 2 + FT, 8'h3F, FT, 2'b01);
        // Ack on the last allowed cycle wins over timeout.
        run_req(1'b0, 4'b0111, FT, 2'b01, 0, 2'b00, ERR_OK, 2 + FT, 8'h37, FT, 2'b01);
        check("active_after_icache", 32'(active_ways_o), 32'o23);

        // Ack on the wrong cache is ignored; real ack in FLUSH cycle 2.
        run_req(1'b0, 4'b0001, 2, 2'b01, 1, 2'b10, ERR_OK, 4, 8'h31, 2, 2'b01);

        // Reset in the second FLUSH cycle of a DCache request.
        @(negedge clk);
        req_cache_i    = 1'b1;
        req_way_mask_i = 4'b0001;
        req_valid_i    = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_flush_req", 32'(flush_req_o), 32'b10);
        rst_ni = 1'b0;
        @(negedge clk);
        check("mid_rst_flush_req", 32'(flush_req_o), 32'd0);
        check("mid_rst_way_mask", 32'(way_mask_o), 32'hFF);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        flush_ack_i = 2'b11;
        @(negedge clk);
        flush_ack_i = 2'b00;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_way_mask", 32'(way_mask_o), 32'hFF);
        check("post_rst_flush_req", 32'(flush_req_o), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
